param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO; next generation of the board-level switch/LED FIFO. Adds generic width and depth, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with clear. Sits between board I/O (or any upstream producer) and a consumer in the 50 MHz domain.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_dp_mem.sv | 19 +
 rtl/param_sync_fifo.sv | 99 +++++++++
 tb/tb_param_sync_fifo.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, depth helpers and level legality check for param_sync_fifo.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int DEF_AF_LVL = 14;
  localparam int DEF_AE_LVL = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic bit lvls_ok(input int af, input int ae, input int aw);
    return af >= 1 && af <= depth_of(aw) && ae >= 0 && ae < depth_of(aw) && clog2(depth_of(aw)) == aw;
  endfunction
endpackage

// File: rtl/fifo_dp_mem.sv
// fifo_dp_mem: simple dual-port RAM, synchronous write and registered read, no reset.
module fifo_dp_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);
  logic [DATA_W-1:0] mem_q [1 << ADDR_W];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_o <= mem_q[ra_i];
  end
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is a 1-cycle registered read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic              clk_50mhz,
  input  logic              rst_btn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
  if (!lvls_ok(AF_LVL, AE_LVL, ADDR_W)) begin : g_bad_lvls
    $error("param_sync_fifo: AF_LVL must be 1..DEPTH and AE_LVL 0..DEPTH-1");
  end
  logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q, ld_q;
  logic              wr_acc, rd_acc, re, empty_d;
  logic [DATA_W-1:0] ram_rd;
`ifdef FIFO_FWFT_EN
  // ov_q marks a valid head word in the output register; the RAM prefetches behind it.
  logic            ov_q, ov_d;
  logic [ADDR_W:0] ram_cnt;
  assign ram_cnt = wr_ptr_q - rd_ptr_q;
  assign rd_acc  = rd_en & ov_q;
  assign re      = (ram_cnt != '0) & (~ov_q | rd_acc);
  assign ov_d    = re | (ov_q & ~rd_acc);
  assign empty_d = ~ov_d;
  always_ff @(posedge clk_50mhz or posedge rst_btn)
    if (rst_btn) ov_q <= 1'b0;
    else ov_q <= ov_d;
`else
  assign rd_acc  = rd_en & ~empty_q;
  assign re      = rd_acc;
  assign empty_d = count_d == '0;
`endif
  assign wr_acc  = wr_en & (~full_q | rd_acc);
  assign count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
  always_ff @(posedge clk_50mhz or posedge rst_btn) begin
    if (rst_btn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(wr_acc);
      rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(re);
      count_q  <= count_d;
      full_q   <= count_d == DEPTH_C;
      empty_q  <= empty_d;
      af_q     <= count_d >= AF_C;
      ae_q     <= count_d <= AE_C;
      ovf_q    <= (wr_en & full_q & ~rd_acc) | (ovf_q & ~clr_err);
      udf_q    <= (rd_en & empty_q) | (udf_q & ~clr_err);
      ld_q     <= ld_q | re;
    end
  end
  fifo_dp_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk_i(clk_50mhz),
    .we_i (wr_acc),
    .wa_i (wr_ptr_q[ADDR_W-1:0]),
    .wd_i (din),
    .re_i (re),
    .ra_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_o (ram_rd)
  );
  // The RAM read register has no reset, so dout is forced to zero until the first read.
  assign dout         = ld_q ? ram_rd : '0;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed self-checking bench for param_sync_fifo (default build).
module tb_param_sync_fifo;
  logic       clk_50mhz = 1'b0;
  logic       rst_btn = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q [$];
  logic [7:0] exp_d;

  param_sync_fifo dut (
    .clk_50mhz(clk_50mhz), .rst_btn(rst_btn), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .clr_err(clr_err), .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; din = d; rd_en = r; clr_err = c;
    @(posedge clk_50mhz); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk_50mhz);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_btn = 1'b0;
    // basic write / read
    cyc(1, 8'hAA, 0, 0);
    cyc(1, 8'hBB, 0, 0);
    cyc(1, 8'hCC, 0, 0);
    chk("t1_count3", count, 3);
    chk("t1_empty", empty, 0);
    chk("t1_ae", almost_empty, 0);
    cyc(0, 0, 1, 0); chk("t1_rd0", dout, 8'hAA); chk("t1_cnt2", count, 2);
    cyc(0, 0, 1, 0); chk("t1_rd1", dout, 8'hBB);
    cyc(0, 0, 1, 0); chk("t1_rd2", dout, 8'hCC);
    chk("t1_empty_end", empty, 1);
    chk("t1_count_end", count, 0);
    // fill to full, overflow
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("t2_cnt", count, i + 1);
      chk("t2_af", almost_full, (i + 1) >= 14);
      chk("t2_full", full, (i + 1) == 16);
    end
    cyc(1, 8'h55, 0, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_cnt16", count, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk("t2_rd", dout, 8'(i));
      chk("t2_rdcnt", count, 15 - i);
    end
    chk("t2_empty", empty, 1);
    cyc(0, 0, 0, 1);
    chk("t2_ovf_clr", overflow, 0);
    // underflow and clear precedence
    cyc(0, 0, 1, 0);
    chk("t3_udf", underflow, 1);
    chk("t3_dout_hold", dout, 8'h0F);
    chk("t3_cnt", count, 0);
    cyc(0, 0, 0, 1);
    chk("t3_udf_clr", underflow, 0);
    cyc(0, 0, 1, 1);
    chk("t3_set_wins", underflow, 1);
    cyc(0, 0, 0, 1);
    chk("t3_udf_clr2", underflow, 0);
    // simultaneous at full
    for (int i = 0; i < 16; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    chk("t4_full", full, 1);
    cyc(1, 8'h77, 1, 0);
    chk("t4_cnt", count, 16);
    chk("t4_ovf", overflow, 0);
    chk("t4_head", dout, 8'h10);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk("t4_rd", dout, (i == 15) ? 8'h77 : 8'h11 + 8'(i));
    end
    chk("t4_empty", empty, 1);
    // simultaneous at empty
    cyc(1, 8'h5A, 1, 0);
    chk("t5_cnt", count, 1);
    chk("t5_udf", underflow, 1);
    chk("t5_empty", empty, 0);
    chk("t5_dout", dout, 8'h77);
    cyc(0, 0, 1, 1);
    chk("t5_rd", dout, 8'h5A);
    chk("t5_udf_clr", underflow, 0);
    // wrap with steady occupancy 5
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'hE0 + 8'(i), 0, 0);
      q.push_back(8'hE0 + 8'(i));
    end
    for (int k = 0; k < 40; k++) begin
      q.push_back(8'(k));
      exp_d = q.pop_front();
      cyc(1, 8'(k), 1, 0);
      chk("t6_dout", dout, exp_d);
      chk("t6_cnt", count, 5);
      chk("t6_flags", {full, empty, almost_full, almost_empty, overflow, underflow}, 6'b0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_d = q.pop_front();
      cyc(0, 0, 1, 0);
      chk("t6_drain", dout, exp_d);
    end
    chk("t6_empty", empty, 1);
    // asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) cyc(1, 8'h30 + 8'(i), 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 8'h37, 0, 0);
    chk("t7_cnt7", count, 7);
    chk("t7_dout_pre", dout, 8'h30);
    #3 rst_btn = 1'b1;
    #1;
    chk("t7_rst_cnt", count, 0);
    chk("t7_rst_empty", empty, 1);
    chk("t7_rst_dout", dout, 8'h00);
    @(posedge clk_50mhz); #1;
    rst_btn = 1'b0;
    cyc(1, 8'hC3, 0, 0);
    chk("t7_cnt1", count, 1);
    cyc(0, 0, 1, 0);
    chk("t7_rd", dout, 8'hC3);
    chk("t7_empty", empty, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
